// File: rtl/kernel_bc_hls_deadlock_confirm_unit.sv
// kernel_bc_hls_deadlock_confirm_unit
//
// Per-process deadlock confirmation unit for an HLS dependency graph.
// - Incoming dependency vectors are merged and forwarded on the out channels
//   together with this process's own bit.
// - If the process depends on itself for CONFIRM_CYCLES consecutive cycles,
//   a deadlock report is raised.
// - The report holds until token_clear is asserted.
//
// Ports
//   clock, reset               rising-edge clock, async active-low reset
//   proc_dep_vld_vec     in    process blocked on each out channel
//   in_chan_dep_vld_vec  in    incoming channel dependency valid
//   in_chan_dep_data_vec in    incoming dependency vectors, channel i at [i*PROC_NUM +: PROC_NUM]
//   token_in_vec         in    incoming token per in channel
//   dl_detect_in         in    global deadlock flag (freezes dependency updates)
//   origin               in    this process is the token source
//   token_clear          in    report acknowledge; clears the confirmation state
//   out_chan_dep_vld_vec out   forwarded blocked flags
//   out_chan_dep_data    out   forwarded dependency vector, including self bit
//   token_out_vec        out   token forwarded on blocked out channels
//   dl_detect_out        out   high while a deadlock is being reported
//   dl_chan_vec          out   blocked out channels captured at report entry
//   dl_cycle_cnt         out   cycles spent in report, saturating
module kernel_bc_hls_deadlock_confirm_unit #(
    parameter int PROC_NUM       = 4,
    parameter int PROC_ID        = 0,
    parameter int IN_CHAN_NUM    = 2,
    parameter int OUT_CHAN_NUM   = 3,
    parameter int CONFIRM_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic                            reset,
    input  logic                            clock,
    input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
    input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
    input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
    input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
    input  logic                            dl_detect_in,
    input  logic                            origin,
    input  logic                            token_clear,
    output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
    output logic [PROC_NUM-1:0]             out_chan_dep_data,
    output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
    output logic                            dl_detect_out,
    output logic [OUT_CHAN_NUM-1:0]         dl_chan_vec,
    output logic [CNT_W-1:0]                dl_cycle_cnt
);

    typedef enum logic [1:0] {IDLE, ARMED, REPORT} state_t;

    localparam logic [CNT_W-1:0]    CNT_MAX      = '1;
    localparam logic [CNT_W-1:0]    CONFIRM_LAST = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [PROC_NUM-1:0] SELF_BIT     = PROC_NUM'(1) << PROC_ID;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PROC_NUM-1:0]     dep_reg_q, dep_reg_d;
    logic [OUT_CHAN_NUM-1:0] token_out_q, token_out_d;
    logic                    dl_detect_q, dl_detect_d;
    logic [OUT_CHAN_NUM-1:0] dl_chan_q, dl_chan_d;
    logic [CNT_W-1:0]        dl_cycle_cnt_q, dl_cycle_cnt_d;

    logic [PROC_NUM-1:0]     dep_comb, dep_sel;
    logic                    upd, blocked, self_dep;

    // Merge all valid incoming dependency vectors.
    always_comb begin
        dep_comb = '0;
        for (int i = 0; i < IN_CHAN_NUM; i++) begin
            if (in_chan_dep_vld_vec[i]) begin
                dep_comb = dep_comb | in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
            end
        end
    end

    // Once a global deadlock is flagged, the dependency snapshot is frozen.
    // Only an arriving token can refresh it.
    assign upd      = ~dl_detect_in | (|token_in_vec);
    assign dep_sel  = upd ? dep_comb : dep_reg_q;
    assign blocked  = |proc_dep_vld_vec;
    assign self_dep = upd & dep_sel[PROC_ID] & blocked;

    assign dep_reg_d   = blocked ? dep_sel : '0;
    assign token_out_d = (((|token_in_vec) & ~token_clear) | origin) ? proc_dep_vld_vec : '0;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        dl_chan_d      = dl_chan_q;
        dl_cycle_cnt_d = '0;
        if (token_clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (self_dep) begin
                        if (CONFIRM_CYCLES == 1) begin
                            state_d = REPORT;
                        end else begin
                            state_d = ARMED;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ARMED: begin
                    // Any gap in self-dependency restarts confirmation from zero.
                    if (!self_dep) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CONFIRM_LAST) begin
                        state_d = REPORT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                REPORT: begin
                    dl_cycle_cnt_d = (dl_cycle_cnt_q == CNT_MAX) ? CNT_MAX
                                                                 : dl_cycle_cnt_q + CNT_W'(1);
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        // Report entry: snapshot blocked channels.
        // The first report cycle counts as cycle 1.
        if (state_d == REPORT && state_q != REPORT) begin
            dl_chan_d      = proc_dep_vld_vec;
            dl_cycle_cnt_d = CNT_W'(1);
        end
        dl_detect_d = (state_d == REPORT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            dep_reg_q      <= '0;
            token_out_q    <= '0;
            dl_detect_q    <= 1'b0;
            dl_chan_q      <= '0;
            dl_cycle_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dep_reg_q      <= dep_reg_d;
            token_out_q    <= token_out_d;
            dl_detect_q    <= dl_detect_d;
            dl_chan_q      <= dl_chan_d;
            dl_cycle_cnt_q <= dl_cycle_cnt_d;
        end
    end

    assign out_chan_dep_vld_vec = proc_dep_vld_vec;
    assign out_chan_dep_data    = dep_reg_q | SELF_BIT;
    assign token_out_vec        = token_out_q;
    assign dl_detect_out        = dl_detect_q;
    assign dl_chan_vec          = dl_chan_q;
    assign dl_cycle_cnt         = dl_cycle_cnt_q;

endmodule

// File: tb/tb_kernel_bc_hls_deadlock_confirm_unit.sv
// Testbench for kernel_bc_hls_deadlock_confirm_unit (PROC_ID=1, CONFIRM_CYCLES=4, CNT_W=4).
// Directed scenarios, then randomized traffic.
// All results are compared against a streak-counting reference model.
module tb_kernel_bc_hls_deadlock_confirm_unit;

    localparam int PN  = 4;
    localparam int PID = 1;
    localparam int ICN = 2;
    localparam int OCN = 3;
    localparam int CC  = 4;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            reset, clock;
    logic [OCN-1:0]  pvld;
    logic [ICN-1:0]  ch_vld;
    logic [ICN*PN-1:0] ch_data;
    logic [ICN-1:0]  tok_in;
    logic            dl_in, origin, clr;
    logic [OCN-1:0]  o_vld;
    logic [PN-1:0]   o_data;
    logic [OCN-1:0]  o_tok;
    logic            o_det;
    logic [OCN-1:0]  o_chan;
    logic [CW-1:0]   o_cyc;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [PN-1:0]  m_dep;
    logic [OCN-1:0] m_tok, m_chan;
    int             m_streak, m_cyc;
    bit             m_rep;

    kernel_bc_hls_deadlock_confirm_unit #(
        .PROC_NUM(PN), .PROC_ID(PID), .IN_CHAN_NUM(ICN), .OUT_CHAN_NUM(OCN),
        .CONFIRM_CYCLES(CC), .CNT_W(CW)
    ) dut (
        .reset(reset), .clock(clock),
        .proc_dep_vld_vec(pvld), .in_chan_dep_vld_vec(ch_vld),
        .in_chan_dep_data_vec(ch_data), .token_in_vec(tok_in),
        .dl_detect_in(dl_in), .origin(origin), .token_clear(clr),
        .out_chan_dep_vld_vec(o_vld), .out_chan_dep_data(o_data),
        .token_out_vec(o_tok), .dl_detect_out(o_det),
        .dl_chan_vec(o_chan), .dl_cycle_cnt(o_cyc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dep = '0; m_tok = '0; m_chan = '0;
        m_streak = 0; m_cyc = 0; m_rep = 0;
    endtask

    // One clock of the reference model, from the inputs currently driven.
    // A report is raised once CC consecutive self-dependent cycles have been seen.
    task automatic model_step();
        logic [PN-1:0] comb, sel;
        bit upd, self_d;
        comb = '0;
        for (int i = 0; i < ICN; i++) if (ch_vld[i]) comb = comb | ch_data[i*PN +: PN];
        upd    = !dl_in || (tok_in != 0);
        sel    = upd ? comb : m_dep;
        self_d = upd && sel[PID] && (pvld != 0);
        m_dep  = (pvld != 0) ? sel : '0;
        m_tok  = (((tok_in != 0) && !clr) || origin) ? pvld : '0;
        if (clr) begin
            m_streak = 0; m_rep = 0; m_cyc = 0;
        end else if (m_rep) begin
            m_cyc = (m_cyc == CMAX) ? CMAX : m_cyc + 1;
        end else if (self_d) begin
            m_streak++;
            if (m_streak >= CC) begin
                m_rep = 1; m_cyc = 1; m_chan = pvld; m_streak = 0;
            end
        end else begin
            m_streak = 0;
        end
    endtask

    task automatic check_all();
        chk("vld",  32'(o_vld),  32'(pvld));
        chk("data", 32'(o_data), 32'(m_dep | PN'(1 << PID)));
        chk("tok",  32'(o_tok),  32'(m_tok));
        chk("det",  32'(o_det),  32'(m_rep));
        chk("chan", 32'(o_chan), 32'(m_chan));
        chk("cyc",  32'(o_cyc),  32'(m_cyc));
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b0; pvld = '0; ch_vld = '0; ch_data = '0; tok_in = '0;
        dl_in = 1'b0; origin = 1'b0; clr = 1'b0;
        model_reset();
        #12;
        check_all();
        #5 reset = 1'b1;

        // Self-dependency held: report after CC cycles
        pvld = 3'b001; ch_vld = 2'b01; ch_data = 8'b0000_0010;
        repeat (3) tick();
        chk("pre_report_det", 32'(o_det), 32'd0);
        tick();
        chk("report_det", 32'(o_det), 32'd1);
        chk("report_chan", 32'(o_chan), 32'b001);
        repeat (9) tick();
        chk("cyc_10", 32'(o_cyc), 32'd10);
        clr = 1'b1; tick();
        chk("clear_det", 32'(o_det), 32'd0);
        chk("clear_cyc", 32'(o_cyc), 32'd0);
        clr = 1'b0;

        // Single-cycle drop restarts confirmation
        repeat (3) tick();
        ch_vld = 2'b00; tick();
        ch_vld = 2'b01;
        repeat (3) tick();
        chk("drop_no_report", 32'(o_det), 32'd0);
        tick();
        chk("drop_report", 32'(o_det), 32'd1);
        clr = 1'b1; ch_vld = 2'b00; tick();
        clr = 1'b0;

        // Frozen dependency under global deadlock, token refresh
        ch_vld = 2'b01; ch_data = 8'b0000_0100; tick();
        chk("dep_load", 32'(o_data), 32'b0110);
        dl_in = 1'b1; ch_data = 8'b0000_1000; tick();
        chk("dep_frozen", 32'(o_data), 32'b0110);
        tok_in = 2'b01; tick();
        chk("dep_token", 32'(o_data), 32'b1010);

        // Token forwarding: origin overrides clear
        tok_in = 2'b00; origin = 1'b1; clr = 1'b1; pvld = 3'b110; tick();
        chk("tok_origin", 32'(o_tok), 32'b110);
        origin = 1'b0; tick();
        chk("tok_cleared", 32'(o_tok), 32'd0);
        tok_in = 2'b01; tick();
        chk("tok_in_cleared", 32'(o_tok), 32'd0);
        clr = 1'b0; tick();
        chk("tok_pass", 32'(o_tok), 32'b110);
        tok_in = 2'b00;

        // Async reset mid-confirmation
        dl_in = 1'b0; pvld = 3'b001; ch_vld = 2'b01; ch_data = 8'b0000_0010;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_det", 32'(o_det), 32'd0);
        chk("rst_tok", 32'(o_tok), 32'd0);
        chk("rst_data", 32'(o_data), 32'b0010);
        check_all();
        #2 reset = 1'b1;
        repeat (3) tick();
        chk("post_rst_no_report", 32'(o_det), 32'd0);
        tick();
        chk("post_rst_report", 32'(o_det), 32'd1);

        // Cycle counter saturation
        repeat (20) tick();
        chk("cyc_sat", 32'(o_cyc), 32'(CMAX));
        clr = 1'b1; tick();
        clr = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            ch_data = ICN*PN'($urandom);
            if ($urandom_range(1, 0) == 1) ch_data[PID] = 1'b1;
            ch_vld  = ICN'($urandom);
            if ($urandom_range(3, 0) != 0) ch_vld[0] = 1'b1;
            pvld    = ($urandom_range(7, 0) == 0) ? '0 : OCN'($urandom);
            tok_in  = ICN'($urandom);
            dl_in   = ($urandom_range(3, 0) == 0);
            origin  = ($urandom_range(7, 0) == 0);
            clr     = ($urandom_range(19, 0) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
